demux_1to4: RTL

Registered 1-to-4 demultiplexer with valid/ready handshake on the input and on each output channel. It is the distribution counterpart of the 4-to-1 selector in the CPU datapath: one source beat goes to one of four consumers, chosen by a 2-bit select. Each channel has a one-entry holding register, so a stalled consumer blocks only beats addressed to it. Intended uses are write-back routing and forwarding-path fan-out in the pipelined core.

---
 rtl/demux_pkg.sv | 18 +
 rtl/demux_slot.sv | 87 ++++++++
 rtl/demux_1to4.sv | 110 +++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared constants and types for the 1-to-4 registered demux.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_pkg;

    localparam int NUM_CH    = 4;
    localparam int SEL_W     = 2;
    localparam int CNT_W_DEF = 16;

    typedef logic [SEL_W-1:0] sel_t;

endpackage : demux_pkg

`default_nettype wire

// File: rtl/demux_slot.sv
// ============================================================================
//  Module      : demux_slot
//  Description : One-entry holding register for a single demux output channel.
//                Optional delivery counter is built when DEMUX_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_slot #(
    parameter int DATA_W = 32
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic              out_ready_i,
    output logic              full_o,
    output logic [DATA_W-1:0] data_out_o,
    output logic              slot_ready_o
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0]  cnt_o
`endif
);

    logic              full_q;
    logic              full_d;
    logic [DATA_W-1:0] dreg_q;
    logic [DATA_W-1:0] dreg_d;
    logic              w_drain;

    assign w_drain = full_q & out_ready_i;

    // A load in the same cycle as a drain keeps the slot full, giving one
    // beat per cycle; the data register is held (not cleared) after a drain.
    always_comb begin
        full_d = full_q;
        dreg_d = dreg_q;
        if (w_drain) begin
            full_d = 1'b0;
        end
        if (load_i) begin
            full_d = 1'b1;
            dreg_d = data_in_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            dreg_q <= '0;
        end else begin
            full_q <= full_d;
            dreg_q <= dreg_d;
        end
    end

    assign full_o       = full_q;
    assign data_out_o   = dreg_q;
    assign slot_ready_o = ~full_q | out_ready_i;

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, w_drain};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`endif

endmodule : demux_slot

`default_nettype wire

// File: rtl/demux_1to4.sv
// ============================================================================
//  Module      : demux_1to4
//  Description : Registered 1-to-4 demultiplexer with valid/ready handshake on
//                the input and on every output channel. Define DEMUX_CNT_EN to
//                add per-channel delivery counters on cnt0_o..cnt3_o.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_1to4
    import demux_pkg::*;
#(
    parameter int size  = 32
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [size-1:0] data_i,
    input  sel_t            select_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [size-1:0] data0_o,
    output logic [size-1:0] data1_o,
    output logic [size-1:0] data2_o,
    output logic [size-1:0] data3_o,
    output logic            valid0_o,
    output logic            valid1_o,
    output logic            valid2_o,
    output logic            valid3_o,
    input  logic            ready0_i,
    input  logic            ready1_i,
    input  logic            ready2_i,
    input  logic            ready3_i
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt0_o,
    output logic [CNT_W-1:0] cnt1_o,
    output logic [CNT_W-1:0] cnt2_o,
    output logic [CNT_W-1:0] cnt3_o
`endif
);

    logic [NUM_CH-1:0] w_out_ready;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_slot_ready;
    logic [NUM_CH-1:0] w_load;
    logic [size-1:0]   w_data [NUM_CH];
`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0]  w_cnt  [NUM_CH];
`endif

    assign w_out_ready = {ready3_i, ready2_i, ready1_i, ready0_i};

    // Only the addressed slot gates the source, so a stalled consumer holds
    // back just the beats destined for it.
    assign ready_o = ~rst_i & w_slot_ready[select_i];

    always_comb begin
        w_load           = '0;
        w_load[select_i] = valid_i & ready_o;
    end

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
            demux_slot #(
                .DATA_W       (size)
`ifdef DEMUX_CNT_EN
                ,
                .CNT_W        (CNT_W)
`endif
            ) u_slot (
                .clk_i        (clk_i),
                .rst_i        (rst_i),
                .load_i       (w_load[k]),
                .data_in_i    (data_i),
                .out_ready_i  (w_out_ready[k]),
                .full_o       (w_full[k]),
                .data_out_o   (w_data[k]),
                .slot_ready_o (w_slot_ready[k])
`ifdef DEMUX_CNT_EN
                ,
                .cnt_o        (w_cnt[k])
`endif
            );
        end
    endgenerate

    assign valid0_o = w_full[0];
    assign valid1_o = w_full[1];
    assign valid2_o = w_full[2];
    assign valid3_o = w_full[3];

    assign data0_o  = w_data[0];
    assign data1_o  = w_data[1];
    assign data2_o  = w_data[2];
    assign data3_o  = w_data[3];

`ifdef DEMUX_CNT_EN
    assign cnt0_o   = w_cnt[0];
    assign cnt1_o   = w_cnt[1];
    assign cnt2_o   = w_cnt[2];
    assign cnt3_o   = w_cnt[3];
`endif

endmodule : demux_1to4

`default_nettype wire
